// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and entry type for the instruction fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two FIFO with synchronous flush; holds fetch tags and fetched instructions
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push && !flush) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: issues word-aligned fetches, tags them with their PC and buffers
// responses for decode; redirects flush the buffers and drop responses still in flight.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int FQ_DEPTH = 2
) (
    input  logic            pll_1_200MHz,
    input  logic            pll_1_locked_synced,
    input  logic [XLEN-1:0] pc_addr,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int OW = CW + 1;
    logic [CW-1:0] tag_count, buf_count, drop_cnt, outstanding;
    logic [XLEN-1:0] tag_head;
    fetch_entry_t buf_head, buf_in;
    logic tag_full, tag_empty, buf_full, buf_empty;
    logic accept, rsp, keep, room;
    // Every in-flight fetch is either tagged (will be kept) or counted in drop_cnt (will be discarded)
    assign outstanding = tag_count + drop_cnt;
    assign room = OW'(outstanding) + OW'(buf_count) < OW'(FQ_DEPTH);
    assign imem_req_valid = pll_1_locked_synced && !redirect_valid && room && !tag_full && !buf_full;
    assign imem_req_addr = word_align(pc_addr);
    assign accept = imem_req_valid && imem_req_ready;
    assign rsp = imem_rsp_valid && (!tag_empty || drop_cnt != '0);
    assign keep = rsp && drop_cnt == '0 && !redirect_valid;
    assign pc_next = redirect_valid ? word_align(redirect_target) : accept ? pc_addr + 32'd4 : pc_addr;
    assign buf_in = '{pc: tag_head, instr: imem_rsp_data};
    assign if_valid = !buf_empty;
    assign if_pc = buf_empty ? '0 : buf_head.pc;
    assign if_instr = buf_empty ? INSTR_NOP : buf_head.instr;
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) tag_q (
        .clk(pll_1_200MHz),
        .rst_n(pll_1_locked_synced),
        .push(accept),
        .pop(keep),
        .flush(redirect_valid),
        .din(imem_req_addr),
        .dout(tag_head),
        .full(tag_full),
        .empty(tag_empty),
        .count(tag_count)
    );
    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FQ_DEPTH)) instr_buf (
        .clk(pll_1_200MHz),
        .rst_n(pll_1_locked_synced),
        .push(keep),
        .pop(if_valid && if_ready),
        .flush(redirect_valid),
        .din(buf_in),
        .dout(buf_head),
        .full(buf_full),
        .empty(buf_empty),
        .count(buf_count)
    );
    always_ff @(posedge pll_1_200MHz or negedge pll_1_locked_synced) begin
        if (!pll_1_locked_synced)
            drop_cnt <= '0;
        else
            drop_cnt <= redirect_valid ? outstanding - CW'(rsp) : drop_cnt - CW'(rsp && drop_cnt != '0);
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the fetch stage and an in-order memory.
module tb_instruction_fetch;
    import fetch_pkg::*;
    localparam int D = 2;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc_addr = '0, pc_next, redirect_target = '0, imem_req_addr, imem_rsp_data = '0;
    logic [31:0] if_pc, if_instr;
    logic redirect_valid = 1'b0, imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
    logic if_valid, if_ready = 1'b0;
    int errors = 0, checks = 0, cyc = 0, n_req = 0;
    logic [31:0] pc_reg = '0;
    typedef struct {logic [31:0] pc; bit drop;} fl_t;
    typedef struct {logic [31:0] addr; int due;} mr_t;
    typedef struct {
        logic [31:0] pc; bit rv; logic [31:0] tgt; bit rdy;
        bit e_vld; logic [31:0] e_addr; logic [31:0] e_next;
    } vec_t;
    fl_t inflight[$];
    fetch_entry_t ibuf[$];
    mr_t memq[$];
    logic [31:0] dut_got[$];
    vec_t vec[8];

    always #5 clk = ~clk;

    instruction_fetch #(.FQ_DEPTH(D)) dut (
        .pll_1_200MHz(clk),
        .pll_1_locked_synced(rst_n),
        .pc_addr(pc_addr),
        .pc_next(pc_next),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_pc(if_pc),
        .if_instr(if_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_if_valid", if_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, INSTR_NOP);
        inflight.delete();
        ibuf.delete();
        memq.delete();
        dut_got.delete();
        pc_reg = '0;
        n_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, compare against the model, then advance the model past the edge
    task automatic step(input bit rv, input logic [31:0] tgt, input bit rdy, input bit ifr,
                        input int lat, input bit spur);
        bit e_vld, acc, rsp;
        logic [31:0] e_addr, e_next;
        fetch_entry_t e_head;
        fl_t f;
        @(negedge clk);
        pc_addr = pc_reg;
        redirect_valid = rv;
        redirect_target = tgt;
        imem_req_ready = rdy;
        if_ready = ifr;
        rsp = memq.size() != 0 && memq[0].due <= cyc;
        imem_rsp_valid = rsp || (spur && memq.size() == 0);
        imem_rsp_data = rsp ? mem_word(memq[0].addr) : 32'hDEAD_BEEF;
        #1;
        e_vld = (inflight.size() + ibuf.size() < D) && !rv;
        e_addr = pc_reg & ~32'h3;
        acc = e_vld && rdy;
        e_next = rv ? (tgt & ~32'h3) : acc ? pc_reg + 32'd4 : pc_reg;
        e_head = ibuf.size() != 0 ? ibuf[0] : '{pc: 32'h0, instr: INSTR_NOP};
        chk("req_valid", imem_req_valid, e_vld);
        chk("req_addr", imem_req_addr, e_addr);
        chk("pc_next", pc_next, e_next);
        chk("if_valid", if_valid, ibuf.size() != 0);
        chk("if_pc", if_pc, e_head.pc);
        chk("if_instr", if_instr, e_head.instr);
        if (if_valid && ifr) dut_got.push_back(if_pc);
        if (imem_req_valid && rdy) begin
            n_req++;
            memq.push_back('{addr: imem_req_addr, due: cyc + lat});
        end
        if (rsp) void'(memq.pop_front());
        if (ibuf.size() != 0 && ifr) void'(ibuf.pop_front());
        if (imem_rsp_valid && inflight.size() != 0) begin
            f = inflight.pop_front();
            if (!f.drop && !rv) ibuf.push_back('{pc: f.pc, instr: imem_rsp_data});
        end
        if (rv) begin
            ibuf.delete();
            foreach (inflight[i]) inflight[i].drop = 1'b1;
        end
        if (acc) inflight.push_back('{pc: e_addr, drop: 1'b0});
        pc_reg = e_next;
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec[0] = '{32'h0000_1003, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_1000, 32'h0000_1003};
        vec[1] = '{32'h0000_1003, 1'b1, 32'h0000_0103, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0100};
        vec[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
        vec[3] = '{32'h0000_0000, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vec[4] = '{32'h2222_2226, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2222_2224, 32'h2222_222A};
        vec[5] = '{32'h0000_0040, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040};
        vec[6] = '{32'h0000_0040, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FFFC};
        vec[7] = '{32'h0000_0047, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0044, 32'h0000_0047};
        do_reset();
        foreach (vec[i]) begin
            @(negedge clk);
            pc_addr = vec[i].pc;
            redirect_valid = vec[i].rv;
            redirect_target = vec[i].tgt;
            imem_req_ready = vec[i].rdy;
            if_ready = 1'b0;
            imem_rsp_valid = 1'b0;
            #1;
            chk("vec_req_valid", imem_req_valid, vec[i].e_vld);
            chk("vec_req_addr", imem_req_addr, vec[i].e_addr);
            chk("vec_pc_next", pc_next, vec[i].e_next);
            chk("vec_if_valid", if_valid, 0);
        end

        // Streaming from pc 0 with single-cycle memory
        do_reset();
        repeat (10) step(0, 0, 1, 1, 1, 0);
        chk("stream_count", dut_got.size() >= 3, 1);
        if (dut_got.size() >= 3) begin
            chk("stream_pc0", dut_got[0], 32'h0);
            chk("stream_pc1", dut_got[1], 32'h4);
            chk("stream_pc2", dut_got[2], 32'h8);
        end

        // Decode stalled: only FQ_DEPTH requests, then drained in order
        do_reset();
        repeat (10) step(0, 0, 1, 0, 1, 0);
        chk("stall_requests", n_req, 2);
        chk("stall_if_pc", if_pc, 32'h0);
        repeat (4) step(0, 0, 1, 1, 1, 0);
        chk("stall_drain_count", dut_got.size() >= 3, 1);
        if (dut_got.size() >= 3) begin
            chk("drain_pc0", dut_got[0], 32'h0);
            chk("drain_pc1", dut_got[1], 32'h4);
            chk("drain_pc2", dut_got[2], 32'h8);
        end

        // Redirect with two fetches (8, C) in flight
        do_reset();
        pc_reg = 32'h8;
        step(0, 0, 1, 1, 3, 0);
        step(0, 0, 1, 1, 3, 0);
        step(1, 32'h100, 1, 1, 1, 0);
        repeat (8) step(0, 0, 1, 1, 1, 0);
        chk("redir_count", dut_got.size() >= 1, 1);
        if (dut_got.size() >= 1) chk("redir_first_pc", dut_got[0], 32'h100);

        // Redirect in the same cycle as a response
        do_reset();
        pc_reg = 32'h20;
        step(0, 0, 1, 1, 1, 0);
        step(1, 32'h200, 1, 1, 1, 0);
        chk("same_cycle_if_valid", if_valid, 0);
        repeat (5) step(0, 0, 1, 1, 1, 0);
        chk("same_cycle_count", dut_got.size() >= 1, 1);
        if (dut_got.size() >= 1) chk("same_cycle_first_pc", dut_got[0], 32'h200);

        // Stray response with nothing outstanding
        do_reset();
        step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1, 0);
        chk("stray_if_valid", if_valid, 0);

        // Reset with two fetches outstanding, then clean restart
        do_reset();
        step(0, 0, 1, 1, 5, 0);
        step(0, 0, 1, 1, 5, 0);
        do_reset();
        repeat (6) step(0, 0, 1, 1, 1, 0);
        chk("restart_count", dut_got.size() >= 1, 1);
        if (dut_got.size() >= 1) chk("restart_first_pc", dut_got[0], 32'h0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            step($urandom_range(11) == 0, $urandom, $urandom_range(3) != 0,
                 $urandom_range(2) != 0, 1 + $urandom_range(2), $urandom_range(19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
